// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide unit controller: fixed-latency MULT/MULTU/DIV/DIVU
// with HI/LO registers, MTHI/MTLO writes and a D-stage stall request.
module e_mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_Start,
  input  logic [2:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_MDUse,
  output logic        E_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic        D_MDStall
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {ST_IDLE, ST_BUSY} st_e;

  st_e              state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [31:0]      hi_q, lo_q;

  logic is_md, accept, done;

  // Only the four long-latency ops start the engine.
  assign is_md  = (E_MDOp == OP_MULT) || (E_MDOp == OP_MULTU) ||
                  (E_MDOp == OP_DIV)  || (E_MDOp == OP_DIVU);
  assign accept = E_Start && is_md && (state == ST_IDLE);
  assign done   = (state == ST_BUSY) && (cnt == CNT_W'(1));

  // State and cycle counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: load latency on accept, count down while busy.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_BUSY;
          cnt_nxt   = ((E_MDOp == OP_MULT) || (E_MDOp == OP_MULTU)) ?
                      CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
        end
      end
      ST_BUSY: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Operand latch: the result depends only on what was presented at accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= E_MDOp;
      a_q  <= E_A;
      b_q  <= E_B;
    end
  end

  // Result datapath from latched operands.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_zero, div_ovf;
  logic        [31:0] div_b;
  logic signed [31:0] sq, sr;
  logic        [31:0] uq, ur;
  logic        [31:0] res_hi, res_lo;
  logic               res_wr;

  assign prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u   = {32'h0, a_q} * {32'h0, b_q};
  assign div_zero = (b_q == 32'h0);
  assign div_ovf  = (op_q == OP_DIV) && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  // Substituting 1 keeps the divider defined; for the overflow case a/1
  // yields exactly the architected answer (LO=0x80000000, HI=0).
  assign div_b    = (div_zero || div_ovf) ? 32'h1 : b_q;
  assign sq       = $signed(a_q) / $signed(div_b);
  assign sr       = $signed(a_q) % $signed(div_b);
  assign uq       = a_q / div_b;
  assign ur       = a_q % div_b;

  // Select the HI/LO pair for the in-flight op; divide by zero writes nothing.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    res_wr = 1'b0;
    case (op_q)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_wr = 1'b1; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_wr = 1'b1; end
      OP_DIV:   begin res_hi = sr; res_lo = sq; res_wr = !div_zero; end
      OP_DIVU:  begin res_hi = ur; res_lo = uq; res_wr = !div_zero; end
      default:  ;
    endcase
  end

  // HI/LO: result on completion, MTHI/MTLO only when idle with no start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      if (res_wr) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else if ((state == ST_IDLE) && !E_Start) begin
      if (E_MDOp == OP_MTHI) hi_q <= E_A;
      if (E_MDOp == OP_MTLO) lo_q <= E_A;
    end
  end

  assign E_Busy    = (state == ST_BUSY);
  assign E_HI      = hi_q;
  assign E_LO      = lo_q;
  assign D_MDStall = D_MDUse && (E_Busy || (E_Start && is_md));

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model using 64-bit arithmetic.
module tb_e_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_Start;
  logic [2:0]  E_MDOp;
  logic [31:0] E_A, E_B;
  logic        D_MDUse;
  logic        E_Busy;
  logic [31:0] E_HI, E_LO;
  logic        D_MDStall;

  e_mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .E_Start(E_Start), .E_MDOp(E_MDOp),
    .E_A(E_A), .E_B(E_B), .D_MDUse(D_MDUse), .E_Busy(E_Busy),
    .E_HI(E_HI), .E_LO(E_LO), .D_MDStall(D_MDStall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  int          m_left;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_hi, m_lo;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_left = 0; m_op = 0; m_a = 0; m_b = 0; m_hi = 0; m_lo = 0;
  endfunction

  // Architectural result of an op via plain 64-bit arithmetic.
  function automatic void apply_result(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = {32'h0, a} * {32'h0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: if (b != 0) begin
              q = sa / sb; r = sa % sb;
              m_lo = q[31:0]; m_hi = r[31:0];
            end
      3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
  endfunction

  function automatic bit is_long(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  // One clock: check stall before the edge, advance model, check state after.
  task automatic cyc(input string tag);
    #1;
    chk({tag, "_stall"}, D_MDStall, D_MDUse && (m_left > 0 || (E_Start && is_long(E_MDOp))));
    if (m_left == 0) begin
      if (E_Start && is_long(E_MDOp)) begin
        m_op = E_MDOp; m_a = E_A; m_b = E_B;
        m_left = (E_MDOp <= 3'd2) ? 5 : 10;
      end else if (!E_Start && E_MDOp == 3'd5) m_hi = E_A;
      else if (!E_Start && E_MDOp == 3'd6) m_lo = E_A;
    end else if (m_left == 1) begin
      apply_result(m_op, m_a, m_b);
      m_left = 0;
    end else m_left--;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy"}, E_Busy, m_left > 0);
    chk({tag, "_hi"}, E_HI, m_hi);
    chk({tag, "_lo"}, E_LO, m_lo);
  endtask

  task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic use_d);
    E_Start = s; E_MDOp = op; E_A = a; E_B = b; D_MDUse = use_d;
  endtask

  task automatic idle(input int n, input string tag);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] sp [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #3;
    chk("rst_busy", E_Busy, 0);
    chk("rst_hi", E_HI, 0);
    chk("rst_lo", E_LO, 0);
    @(negedge clk);
    reset = 1'b0;

    // signed multiply, accepted on first edge after reset
    drive(1, 3'd1, 32'hFFFF_FFFD, 32'd7, 0);
    cyc("mult_go");
    idle(5, "mult");
    chk("mult_hi_const", E_HI, 32'hFFFF_FFFF);
    chk("mult_lo_const", E_LO, 32'hFFFF_FFEB);

    // unsigned multiply, operands drop to 0 mid-op
    drive(1, 3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    cyc("multu_go");
    drive(0, 0, 32'hFFFF_FFFF, 32'd2, 0);
    cyc("multu_c1");
    drive(0, 0, 0, 0, 0);
    idle(4, "multu");
    chk("multu_hi_const", E_HI, 32'h1);
    chk("multu_lo_const", E_LO, 32'hFFFF_FFFE);

    // signed divide
    drive(1, 3'd3, 32'hFFFF_FFF9, 32'd2, 0);
    cyc("div_go");
    idle(10, "div");
    chk("div_lo_const", E_LO, 32'hFFFF_FFFD);
    chk("div_hi_const", E_HI, 32'hFFFF_FFFF);

    // divide by zero leaves HI/LO alone
    drive(0, 3'd5, 32'h11, 0, 0); cyc("mthi");
    drive(0, 3'd6, 32'h22, 0, 0); cyc("mtlo");
    drive(1, 3'd4, 32'd7, 32'd0, 0);
    cyc("divz_go");
    idle(10, "divz");
    chk("divz_hi_const", E_HI, 32'h11);
    chk("divz_lo_const", E_LO, 32'h22);

    // signed overflow
    drive(1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    cyc("ovf_go");
    idle(10, "ovf");
    chk("ovf_lo_const", E_LO, 32'h8000_0000);
    chk("ovf_hi_const", E_HI, 32'h0);

    // stall while DIVU busy, MTLO and second start ignored
    drive(1, 3'd4, 32'd100, 32'd7, 1);
    cyc("stl_go");
    for (int i = 0; i < 10; i++) begin
      if (i == 2)      drive(0, 3'd6, 32'h55, 0, 1);
      else if (i == 4) drive(1, 3'd1, 32'h3, 32'h3, 1);
      else             drive(0, 0, 0, 0, 1);
      cyc("stl_busy");
    end
    drive(0, 0, 0, 0, 1);
    cyc("stl_after");
    chk("stl_lo_const", E_LO, 32'd14);
    chk("stl_hi_const", E_HI, 32'd2);

    // reset asserted in busy cycle 3 of a MULT
    drive(1, 3'd1, 32'h1234, 32'h5678, 0);
    cyc("rmul_go");
    idle(2, "rmul");
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", E_Busy, 0);
    chk("arst_hi", E_HI, 0);
    chk("arst_lo", E_LO, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(6, "post_rst");
    drive(0, 3'd5, 32'hABCD, 0, 0);
    cyc("mthi2");
    chk("mthi2_const", E_HI, 32'h0000_ABCD);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
            1'($urandom_range(0, 1)));
      cyc("rnd");
    end
    idle(12, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e_mdu_ctrl.md
E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- MULT_CYC, 5, busy cycles for MULT/MULTU.
- DIV_CYC, 10, busy cycles for DIV/DIVU.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-high.
- E_Start, in, 1, E-stage MULT/MULTU/DIV/DIVU issue pulse.
- E_MDOp, in, 3, op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
- E_A, in, 32, rs operand.
- E_B, in, 32, rt operand.
- D_MDUse, in, 1, D-stage instruction uses the MDU (mult/div/mf/mt).
- E_Busy, out, 1, operation in flight.
- E_HI, out, 32, HI register.
- E_LO, out, 32, LO register.
- D_MDStall, out, 1, stall request to the D stage.

Function
REQ-003 Op is accepted only on a rising edge where E_Start=1, E_MDOp is in 1..4 and E_Busy=0; E_A, E_B and E_MDOp are latched into internal registers on that edge.
REQ-004 Accepting edge: counter loads MULT_CYC (ops 1,2) or DIV_CYC (ops 3,4); E_Busy goes to 1.
REQ-005 Each later edge with counter>1 decrements the counter.
REQ-006 Edge with counter==1: counter goes to 0, E_Busy goes to 0, and E_HI/E_LO load the result.
- E_Busy is high for exactly N cycles after the accepting edge.
REQ-007 Result is computed from latched operands only; input changes after acceptance have no effect.
REQ-008 MULT: {E_HI,E_LO} = signed 64-bit product.
- MULTU: unsigned 64-bit product.
REQ-009 DIV: E_LO = signed quotient truncated toward zero; E_HI = remainder with sign of dividend.
- DIVU: unsigned quotient and remainder.
REQ-010 Divisor zero: DIV/DIVU still holds E_Busy for DIV_CYC cycles; E_HI/E_LO SHALL stay unchanged at completion.
REQ-011 Signed overflow 0x80000000 / 0xFFFFFFFF: E_LO=0x80000000, E_HI=0.
REQ-012 MTHI/MTLO (op 5/6): E_HI (E_LO) takes E_A on the edge, only when E_Busy=0 and E_Start=0; otherwise ignored.
REQ-013 E_Start=1 with E_Busy=1 is ignored; the in-flight op is unaffected.
REQ-014 E_Start=1 with op 0, 5, 6 or 7 SHALL NOT start an operation.
- Op 7 has no effect in any case.
REQ-015 D_MDStall = D_MDUse & (E_Busy | (E_Start & E_MDOp in 1..4)), purely combinational.
REQ-016 E_HI/E_LO change only per REQ-006, REQ-012 and reset; they hold between operations.

Reset
REQ-017 While reset=1, independent of clk:
- E_HI=0, E_LO=0, E_Busy=0, counter=0, latched operands=0.
REQ-018 Reset during an operation aborts it; no result is written after reset release.
REQ-019 First edge after reset release SHALL accept E_Start normally.

Verification
REQ-020 MULT, E_A=0xFFFFFFFD (-3), E_B=7 -> E_Busy high 5 cycles, then E_HI=0xFFFFFFFF, E_LO=0xFFFFFFEB.
REQ-021 MULTU, E_A=0xFFFFFFFF, E_B=2 -> after 5 cycles E_HI=0x00000001, E_LO=0xFFFFFFFE.
- E_A/E_B changed to 0 in cycle 2 -> same result.
REQ-022 DIV, E_A=0xFFFFFFF9 (-7), E_B=2 -> E_Busy high 10 cycles, then E_LO=0xFFFFFFFD, E_HI=0xFFFFFFFF.
- DIVU 7/0 with prior HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO unchanged.
REQ-023 DIVU issued; D_MDUse=1 -> D_MDStall=1 in the start cycle and all 10 busy cycles, 0 after.
- MTLO E_A=0x55 while busy -> E_LO unchanged.
- Second E_Start while busy -> ignored.
REQ-024 Assert reset asynchronously in busy cycle 3 of MULT -> outputs zero immediately.
- Counter stays 0 and HI/LO stay 0 after release.
- Fresh MTHI E_A=0xABCD -> E_HI=0x0000ABCD next edge.
